// File: rtl/inv_adder_sample_ctrl_if.sv
// Host-side job request / result handshake bundle for inv_adder_sample_ctrl.
// master = host/test logic, slave = sequencer.
interface inv_adder_sample_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_mode;
  logic [3:0]       req_a;
  logic [3:0]       req_b;
  logic [3:0]       req_sum;
  logic [3:0]       req_i0;
  logic             req_upd;
  logic [CNT_W-1:0] req_steps;
  logic             abort;
  logic             res_valid;
  logic             res_ready;
  logic [3:0]       res_a;
  logic [3:0]       res_b;
  logic [3:0]       res_sum;
  logic             res_ovf;

  modport master (
    output req_valid, req_mode, req_a, req_b, req_sum, req_i0, req_upd, req_steps,
    output abort, res_ready,
    input  req_ready, res_valid, res_a, res_b, res_sum, res_ovf
  );

  modport slave (
    input  req_valid, req_mode, req_a, req_b, req_sum, req_i0, req_upd, req_steps,
    input  abort, res_ready,
    output req_ready, res_valid, res_a, res_b, res_sum, res_ovf
  );
endinterface

// File: rtl/inv_adder_sample_ctrl.sv
// Sequencer for the 4-bit invertible p-bit adder: clamp, burn-in, sample N cycles, majority vote.
// Optional I_0 annealing ramp enabled by defining INV_SAMPLER_ANNEAL_EN.
//
// state   | meaning
// IDLE    | adder held in reset, waiting for a job
// CLAMP   | adder in reset with job clamps applied, ones-counters cleared
// SETTLE  | adder running, burn-in, no counting
// SAMPLE  | accumulate each adder output bit for N cycles
// RESOLVE | majority vote into result registers
// DONE    | result valid, waiting for res_ready
module inv_adder_sample_ctrl #(
  parameter int CNT_W       = 16,
  parameter int BURN_CYCLES = 8,
  parameter int ANNEAL_STEP = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  inv_adder_sample_ctrl_if.slave host,
  output logic                   add_reset,
  output logic [1:0]             add_mode,
  output logic                   add_update_mode,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic [3:0]             add_sum,
  output logic [3:0]             add_i0,
  input  logic [3:0]             add_a_out,
  input  logic [3:0]             add_b_out,
  input  logic [3:0]             add_sum_out,
  input  logic                   add_overflow
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLAMP   = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_SAMPLE  = 3'd3;
  localparam logic [2:0] S_RESOLVE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [CNT_W-1:0] BURN_LOAD = CNT_W'(BURN_CYCLES - 1);

  if (BURN_CYCLES < 1 || ANNEAL_STEP < 1) begin : g_bad_param
    $error("inv_adder_sample_ctrl: BURN_CYCLES and ANNEAL_STEP must be >= 1");
  end

  logic [2:0]       state;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] steps_lat;
  logic [1:0]       mode_lat;
  logic             upd_lat;
  logic [3:0]       a_lat, b_lat, sum_lat, i0_lat;
  logic [CNT_W-1:0] ones_cnt [13];
  logic [12:0]      samp;
  logic [12:0]      vote;
  logic [3:0]       res_a_q, res_b_q, res_sum_q;
  logic             res_ovf_q;
  logic             accept;
  logic             in_job;

  assign host.req_ready = (state == S_IDLE) && !reset;
  assign accept         = host.req_valid && host.req_ready;
  assign in_job         = (state == S_CLAMP) || (state == S_SETTLE) ||
                          (state == S_SAMPLE) || (state == S_RESOLVE);
  assign samp           = {add_overflow, add_sum_out, add_b_out, add_a_out};

  // Tie (2*count == N) resolves to 0; the doubled count needs the extra bit.
  always_comb begin
    vote = '0;
    for (int i = 0; i < 13; i++) begin
      vote[i] = ({ones_cnt[i], 1'b0} > {1'b0, steps_lat});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      timer     <= '0;
      steps_lat <= '0;
      mode_lat  <= '0;
      upd_lat   <= 1'b0;
      a_lat     <= '0;
      b_lat     <= '0;
      sum_lat   <= '0;
      i0_lat    <= '0;
      res_a_q   <= '0;
      res_b_q   <= '0;
      res_sum_q <= '0;
      res_ovf_q <= 1'b0;
      for (int i = 0; i < 13; i++) ones_cnt[i] <= '0;
    end else if (in_job && host.abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            mode_lat  <= host.req_mode;
            upd_lat   <= host.req_upd;
            a_lat     <= host.req_a;
            b_lat     <= host.req_b;
            sum_lat   <= host.req_sum;
            i0_lat    <= host.req_i0;
            steps_lat <= (host.req_steps == '0) ? CNT_W'(1) : host.req_steps;
            state     <= S_CLAMP;
          end
        end
        S_CLAMP: begin
          for (int i = 0; i < 13; i++) ones_cnt[i] <= '0;
          timer <= BURN_LOAD;
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (timer == '0) begin
            timer <= steps_lat - CNT_W'(1);
            state <= S_SAMPLE;
          end else begin
            timer <= timer - CNT_W'(1);
          end
        end
        S_SAMPLE: begin
          for (int i = 0; i < 13; i++) begin
            ones_cnt[i] <= ones_cnt[i] + {{(CNT_W-1){1'b0}}, samp[i]};
          end
          if (timer == '0) state <= S_RESOLVE;
          else             timer <= timer - CNT_W'(1);
        end
        S_RESOLVE: begin
          res_a_q   <= vote[3:0];
          res_b_q   <= vote[7:4];
          res_sum_q <= vote[11:8];
          res_ovf_q <= vote[12];
          state     <= S_DONE;
        end
        S_DONE: begin
          if (host.res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign host.res_valid = (state == S_DONE);
  assign host.res_a     = res_a_q;
  assign host.res_b     = res_b_q;
  assign host.res_sum   = res_sum_q;
  assign host.res_ovf   = res_ovf_q;

  assign add_reset       = reset || (state == S_IDLE) || (state == S_CLAMP) || (state == S_DONE);
  assign add_mode        = mode_lat;
  assign add_update_mode = upd_lat;
  assign add_a           = a_lat;
  assign add_b           = b_lat;
  assign add_sum         = sum_lat;

`ifdef INV_SAMPLER_ANNEAL_EN
  localparam logic [CNT_W-1:0] ANN_LOAD = CNT_W'(ANNEAL_STEP - 1);

  logic [3:0]       i0_cur;
  logic [CNT_W-1:0] ann_tmr;

  // Ramp starts at the accept edge so CLAMP already sees I_0 = 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      i0_cur  <= '0;
      ann_tmr <= '0;
    end else if (accept) begin
      i0_cur  <= (host.req_i0 == 4'd0) ? 4'd0 : 4'd1;
      ann_tmr <= ANN_LOAD;
    end else if (state == S_SETTLE || state == S_SAMPLE) begin
      if (ann_tmr == '0) begin
        ann_tmr <= ANN_LOAD;
        if (i0_cur < i0_lat) i0_cur <= i0_cur + 4'd1;
      end else begin
        ann_tmr <= ann_tmr - CNT_W'(1);
      end
    end
  end

  assign add_i0 = i0_cur;
`else
  assign add_i0 = i0_lat;
`endif

endmodule

// File: tb/tb_inv_adder_sample_ctrl.sv
// Directed bench for inv_adder_sample_ctrl with a behavioural stand-in for the p-bit adder.
module tb_inv_adder_sample_ctrl;
  localparam int CNT_W = 16;
  localparam int BURN  = 8;
  localparam int ASTEP = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  inv_adder_sample_ctrl_if #(.CNT_W(CNT_W)) host ();

  logic       add_reset, add_update_mode, add_overflow;
  logic [1:0] add_mode;
  logic [3:0] add_a, add_b, add_sum, add_i0;
  logic [3:0] add_a_out, add_b_out, add_sum_out;

  inv_adder_sample_ctrl #(.CNT_W(CNT_W), .BURN_CYCLES(BURN), .ANNEAL_STEP(ASTEP)) dut (
    .clk(clk), .reset(reset), .host(host),
    .add_reset(add_reset), .add_mode(add_mode), .add_update_mode(add_update_mode),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_i0(add_i0),
    .add_a_out(add_a_out), .add_b_out(add_b_out), .add_sum_out(add_sum_out),
    .add_overflow(add_overflow)
  );

  // Stand-in adder: 0 = constant 4'hA, 1 = ideal adder with every 4th cycle inverted,
  // 2 = all bits toggle each cycle (first sampled cycle is 1).
  int         stub_sel;
  logic [7:0] ncnt;
  logic [4:0] t_sum;
  logic [3:0] t_b;

  always @(negedge clk) begin
    if (add_reset) ncnt = 8'd0;
    else           ncnt = ncnt + 8'd1;
  end

  always_comb begin
    t_sum        = '0;
    t_b          = '0;
    add_a_out    = 4'hA;
    add_b_out    = 4'hA;
    add_sum_out  = 4'hA;
    add_overflow = 1'b1;
    if (stub_sel == 1) begin
      if (add_mode == 2'd0) t_b = add_b;
      else                  t_b = add_sum - add_a;
      t_sum        = {1'b0, add_a} + {1'b0, t_b};
      add_a_out    = add_a;
      add_b_out    = t_b;
      add_sum_out  = (add_mode == 2'd0) ? t_sum[3:0] : add_sum;
      add_overflow = t_sum[4];
      if (ncnt[1:0] == 2'd0) begin
        add_a_out    = ~add_a_out;
        add_b_out    = ~add_b_out;
        add_sum_out  = ~add_sum_out;
        add_overflow = ~add_overflow;
      end
    end else if (stub_sel == 2) begin
      add_a_out    = {4{ncnt[0]}};
      add_b_out    = {4{ncnt[0]}};
      add_sum_out  = {4{ncnt[0]}};
      add_overflow = ncnt[0];
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic send(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] s, input logic [3:0] i0, input logic upd,
                      input logic [15:0] n);
    bit got;
    host.req_mode  = m;
    host.req_a     = a;
    host.req_b     = b;
    host.req_sum   = s;
    host.req_i0    = i0;
    host.req_upd   = upd;
    host.req_steps = n;
    host.req_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      got = host.req_ready;
      @(posedge clk);
    end
    #1;
    host.req_valid = 1'b0;
    chk("accept", 32'(got), 32'd1);
  endtask

  // Returns latency in cycles counted from the accept cycle (base = cycles already elapsed).
  task automatic wait_res(input int base, input int max, output int lat);
    int cyc;
    cyc = base;
    while (!host.res_valid && cyc < max) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    lat = cyc + 1;
  endtask

  task automatic take();
    host.res_ready = 1'b1;
    @(posedge clk);
    #1;
    host.res_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int rises;
    reset          = 1'b1;
    stub_sel       = 0;
    host.req_valid = 1'b0;
    host.req_mode  = '0;
    host.req_a     = '0;
    host.req_b     = '0;
    host.req_sum   = '0;
    host.req_i0    = '0;
    host.req_upd   = 1'b0;
    host.req_steps = '0;
    host.abort     = 1'b0;
    host.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(host.req_ready), 32'd0);
    chk("rst_res_valid", 32'(host.res_valid), 32'd0);
    chk("rst_add_reset", 32'(add_reset), 32'd1);
    chk("rst_res_sum", 32'(host.res_sum), 32'd0);
    chk("rst_add_a", 32'(add_a), 32'd0);
    chk("rst_add_i0", 32'(add_i0), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_req_ready", 32'(host.req_ready), 32'd1);

    // Latency with constant stub, plus clamp latching.
    send(2'd0, 4'd5, 4'd6, 4'd3, 4'd4, 1'b1, 16'd4);
    host.req_a = 4'hF;
    chk("clamp_add_reset", 32'(add_reset), 32'd1);
    chk("clamp_req_ready", 32'(host.req_ready), 32'd0);
    chk("clamp_add_a", 32'(add_a), 32'd5);
    chk("clamp_add_b", 32'(add_b), 32'd6);
    chk("clamp_add_sum", 32'(add_sum), 32'd3);
    chk("clamp_add_upd", 32'(add_update_mode), 32'd1);
`ifdef INV_SAMPLER_ANNEAL_EN
    chk("clamp_add_i0", 32'(add_i0), 32'd1);
`else
    chk("clamp_add_i0", 32'(add_i0), 32'd4);
`endif
    @(posedge clk);
    #1;
    chk("settle_add_reset", 32'(add_reset), 32'd0);
    chk("settle_add_a", 32'(add_a), 32'd5);
    wait_res(1, 100, lat);
    chk("latency_n4", 32'(lat), 32'd15);
    chk("stub_res_sum", 32'(host.res_sum), 32'hA);
    chk("stub_res_a", 32'(host.res_a), 32'hA);
    chk("stub_res_ovf", 32'(host.res_ovf), 32'd1);
    chk("done_add_reset", 32'(add_reset), 32'd1);
    take();
    chk("after_take_valid", 32'(host.res_valid), 32'd0);
    chk("after_take_ready", 32'(host.req_ready), 32'd1);

    // N = 0 behaves as N = 1.
    send(2'd0, 4'd1, 4'd1, 4'd0, 4'd4, 1'b0, 16'd0);
    wait_res(0, 100, lat);
    chk("latency_n0", 32'(lat), 32'd12);
    chk("n0_res_sum", 32'(host.res_sum), 32'hA);
    take();

    // Forward 1 + 7 with noisy ideal adder.
    stub_sel = 1;
    send(2'd0, 4'd1, 4'd7, 4'd0, 4'd4, 1'b0, 16'd1000);
    wait_res(0, 1100, lat);
    chk("fwd_latency", 32'(lat), 32'd1011);
    chk("fwd_res_sum", 32'(host.res_sum), 32'd8);
    chk("fwd_res_ovf", 32'(host.res_ovf), 32'd0);
    chk("fwd_res_a", 32'(host.res_a), 32'd1);
    chk("fwd_res_b", 32'(host.res_b), 32'd7);
    take();

    // Forward 9 + 8 overflows to sum 1.
    send(2'd0, 4'd9, 4'd8, 4'd0, 4'd4, 1'b0, 16'd20);
    wait_res(0, 100, lat);
    chk("ovf_res_sum", 32'(host.res_sum), 32'd1);
    chk("ovf_res_ovf", 32'(host.res_ovf), 32'd1);
    take();

    // Subtract: b = 12 - 3.
    send(2'd2, 4'd3, 4'd0, 4'd12, 4'd4, 1'b0, 16'd1000);
    wait_res(0, 1100, lat);
    chk("sub_res_b", 32'(host.res_b), 32'd9);
    chk("sub_res_a", 32'(host.res_a), 32'd3);
    chk("sub_res_sum", 32'(host.res_sum), 32'd12);
    chk("sub_res_ovf", 32'(host.res_ovf), 32'd0);
    take();

    // Tie (1 of 2) votes 0; 2 of 3 votes 1.
    stub_sel = 2;
    send(2'd0, 4'd0, 4'd0, 4'd0, 4'd4, 1'b0, 16'd2);
    wait_res(0, 100, lat);
    chk("tie_res_sum", 32'(host.res_sum), 32'd0);
    chk("tie_res_ovf", 32'(host.res_ovf), 32'd0);
    take();
    send(2'd0, 4'd0, 4'd0, 4'd0, 4'd4, 1'b0, 16'd3);
    wait_res(0, 100, lat);
    chk("maj3_res_sum", 32'(host.res_sum), 32'hF);
    chk("maj3_res_ovf", 32'(host.res_ovf), 32'd1);
    take();

    // Backpressure in DONE; new request ignored meanwhile.
    stub_sel = 0;
    send(2'd0, 4'd5, 4'd6, 4'd0, 4'd4, 1'b0, 16'd4);
    wait_res(0, 100, lat);
    host.req_valid = 1'b1;
    host.req_a     = 4'd2;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("bp_res_valid", 32'(host.res_valid), 32'd1);
      chk("bp_req_ready", 32'(host.req_ready), 32'd0);
      chk("bp_res_sum", 32'(host.res_sum), 32'hA);
    end
    host.req_valid = 1'b0;
    chk("bp_add_a_kept", 32'(add_a), 32'd5);
    take();
    for (int k = 0; k < 3; k++) begin
      chk("bp_idle_ready", 32'(host.req_ready), 32'd1);
      @(posedge clk);
      #1;
    end

    // Abort on the 3rd SAMPLE cycle.
    stub_sel = 1;
    send(2'd0, 4'd1, 4'd2, 4'd0, 4'd4, 1'b0, 16'd10);
    repeat (11) @(posedge clk);
    #1;
    host.abort = 1'b1;
    @(posedge clk);
    #1;
    host.abort = 1'b0;
    chk("abort_req_ready", 32'(host.req_ready), 32'd1);
    chk("abort_add_reset", 32'(add_reset), 32'd1);
    rises = 0;
    for (int k = 0; k < 30; k++) begin
      if (host.res_valid) rises++;
      @(posedge clk);
      #1;
    end
    chk("abort_no_valid", 32'(rises), 32'd0);
    chk("abort_res_kept", 32'(host.res_sum), 32'hA);
    send(2'd0, 4'd2, 4'd3, 4'd0, 4'd4, 1'b0, 16'd8);
    wait_res(0, 100, lat);
    chk("post_abort_lat", 32'(lat), 32'd19);
    chk("post_abort_sum", 32'(host.res_sum), 32'd5);
    // abort together with res_ready in DONE is a normal accept.
    host.abort = 1'b1;
    take();
    host.abort = 1'b0;
    chk("abort_done_ready", 32'(host.req_ready), 32'd1);
    chk("abort_done_res", 32'(host.res_sum), 32'd5);

    // Reset pulse during SETTLE.
    send(2'd1, 4'd7, 4'd2, 4'd9, 4'd4, 1'b1, 16'd4);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_req_ready", 32'(host.req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_mid_valid", 32'(host.res_valid), 32'd0);
    chk("rst_mid_add_reset", 32'(add_reset), 32'd1);
    chk("rst_mid_res_sum", 32'(host.res_sum), 32'd0);
    chk("rst_mid_add_a", 32'(add_a), 32'd0);
    chk("rst_mid_add_mode", 32'(add_mode), 32'd0);
    chk("rst_mid_add_i0", 32'(add_i0), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_idle", 32'(host.req_ready), 32'd1);

`ifdef INV_SAMPLER_ANNEAL_EN
    send(2'd0, 4'd1, 4'd1, 4'd0, 4'd4, 1'b0, 16'd20);
    for (int c = 1; c <= 14; c++) begin
      int e;
      e = (c < 2) ? 1 : 1 + (c - 2) / 2;
      if (e > 4) e = 4;
      chk("anneal_i0", 32'(add_i0), 32'(e));
      @(posedge clk);
      #1;
    end
    wait_res(15, 100, lat);
    take();
    send(2'd0, 4'd1, 4'd1, 4'd0, 4'd0, 1'b0, 16'd4);
    for (int c = 1; c <= 8; c++) begin
      chk("anneal_i0_zero", 32'(add_i0), 32'd0);
      @(posedge clk);
      #1;
    end
    wait_res(9, 100, lat);
    take();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
